// File: rtl/piso_unloader.sv
// piso_unloader: parallel-in serial-out unloader with valid/ready load and per-bit hold.
// Optional macro PISO_UNLOADER_PARITY_EN appends an even-parity bit after the data bits.
module piso_unloader #(
    parameter int N         = 8,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         frame_start,
    output logic         done,
    output logic         busy
);

    localparam int BW = $clog2(N + 2);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef PISO_UNLOADER_PARITY_EN
    localparam int NBITS = N + 1;
`else
    localparam int NBITS = N;
`endif
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          ser_out_q, ser_out_d;
    logic          ser_valid_q, ser_valid_d;
    logic          frame_start_q, frame_start_d;
    logic          done_q, done_d;
`ifdef PISO_UNLOADER_PARITY_EN
    localparam logic [BW-1:0] LAST_DATA = BW'(N - 1);
    logic          parity_q, parity_d;
`endif

    logic          accept;
    logic          tick;
    logic          next_bit;
    logic [N-1:0]  shreg_shift;

    assign in_ready    = (state_q == S_IDLE) && reset;
    assign accept      = in_valid && in_ready;
    assign tick        = en && (div_cnt_q == DIV_LAST);
    assign busy        = (state_q != S_IDLE);
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;

    // The register shifts toward the output end, so the next bit sits next to it.
    assign shreg_shift = MSB_FIRST ? {shreg_q[N-2:0], 1'b0}
                                   : {1'b0, shreg_q[N-1:1]};

    always_comb begin
        next_bit = MSB_FIRST ? shreg_q[N-2] : shreg_q[1];
`ifdef PISO_UNLOADER_PARITY_EN
        if (bit_cnt_q == LAST_DATA) begin
            next_bit = parity_q;
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        div_cnt_d     = div_cnt_q;
        ser_out_d     = ser_out_q;
        ser_valid_d   = ser_valid_q;
        frame_start_d = frame_start_q;
        done_d        = done_q;
`ifdef PISO_UNLOADER_PARITY_EN
        parity_d      = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (accept) begin
                    state_d       = S_SHIFT;
                    shreg_d       = in;
                    bit_cnt_d     = '0;
                    div_cnt_d     = '0;
                    ser_out_d     = MSB_FIRST ? in[N-1] : in[0];
                    ser_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
`ifdef PISO_UNLOADER_PARITY_EN
                    parity_d      = ^in;
`endif
                end
            end
            S_SHIFT: begin
                if (en) begin
                    frame_start_d = 1'b0;
                end
                if (tick) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d     = S_DONE;
                        shreg_d     = '0;
                        ser_out_d   = 1'b0;
                        ser_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = shreg_shift;
                        ser_out_d = next_bit;
                    end
                end else if (en) begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d       = S_IDLE;
                ser_out_d     = 1'b0;
                ser_valid_d   = 1'b0;
                frame_start_d = 1'b0;
                done_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            div_cnt_q     <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            div_cnt_q     <= div_cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

`ifdef PISO_UNLOADER_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: doc/piso_unloader.md
Name: piso_unloader

Overview:
- Parallel-in, serial-out unloader: the read side of the parallel word registers.
- Accepts an N-bit word over a valid/ready handshake and drives it out one bit at a time.
- Each bit is held for a programmable number of enabled clock cycles.
- Feeds serial links and LED/shift-chain drivers on the board.

Parameters:
N, 8, data word width (>=2)
DIV, 1, enabled clk cycles per serial bit (>=1)
MSB_FIRST, 1, 1 = bit N-1 sent first, 0 = bit 0 sent first

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  global advance enable; 0 stalls the bit-period counter
in_valid  input  1  producer has a word on in
in_ready  output  1  block can accept a word this cycle
in  input  N  parallel word to serialise
ser_out  output  1  serial data bit (registered)
ser_valid  output  1  ser_out carries a data/parity bit
frame_start  output  1  high during the first cycle of bit 0 of a frame
done  output  1  one-cycle pulse after the last bit of a frame
busy  output  1  high in SHIFT and DONE states

Behaviour:
- States: IDLE, SHIFT, DONE. Binary encoded.
- Reset (reset=0, async), applied immediately:
  - state=IDLE; shift register, bit counter and div counter cleared.
  - ser_out=0, ser_valid=0, frame_start=0, done=0, busy=0.
  - in_ready is forced to 0 while reset is asserted.
- in_ready = (state==IDLE) && reset deasserted. Combinational.
- Transfer occurs on a rising edge with in_valid && in_ready. In that edge:
  - in is loaded into the shift register.
  - bit counter=0, div counter=0, state goes to SHIFT.
  - ser_out takes the first bit (in[N-1] if MSB_FIRST, else in[0]).
  - ser_valid=1, frame_start=1, busy=1.
  - Latency: first bit is visible in the cycle after the accepting edge.
- SHIFT state:
  - The div counter increments on each edge with en=1.
  - When the div counter reaches DIV-1 with en=1, it clears and the next bit is presented.
  - frame_start drops after the first enabled cycle of bit 0.
  - en=0: all counters, ser_out and frame_start are frozen; ser_valid stays 1.
  - in_valid is ignored; in_ready=0.
- After the final bit's DIV enabled cycles: state=DONE.
  - ser_valid=0, ser_out=0, done=1 for exactly one cycle; busy stays 1.
  - DONE always advances to IDLE on the next edge, independent of en.
- Frame length with en held 1:
  - N*DIV cycles of bits, plus 1 DONE cycle.
  - Earliest next accept is in the following IDLE cycle.
  - Back-to-back frame period is N*DIV+2 cycles.
- Widths:
  - bit counter is $clog2(N+2) bits.
  - div counter is max(1,$clog2(DIV)) bits.
  - Counters never wrap within a frame; they are cleared on load.
- Reset mid-frame aborts immediately. The partial word is discarded, with no done pulse, and the block returns to IDLE.
- A word presented while busy is not consumed. The producer must hold in_valid/in until in_ready=1.

Optional Feature:
- Macro: PISO_UNLOADER_PARITY_EN.
- Defined:
  - After the N data bits, one extra bit is sent with ser_valid=1: even parity, i.e. XOR of the loaded word.
  - The bit lasts DIV enabled cycles.
  - Frame = (N+1)*DIV bit cycles + 1 DONE cycle.
  - done follows the parity bit.
- Undefined:
  - Frame is N data bits only.
  - No parity logic or storage is synthesised.

Test Plan:
1. Reset: hold reset=0 with in_valid=1 -> in_ready=0 and all outputs 0. Release -> in_ready=1 in the first cycle, with no stray transfer before that edge.
2. N=8, DIV=1, MSB_FIRST=1, in=8'hA5 accepted at edge 0 -> cycles 1..8:
   - ser_out=1,0,1,0,0,1,0,1 with ser_valid=1.
   - frame_start only in cycle 1.
   - done=1 in cycle 9; in_ready=1 in cycle 10.
3. DIV=3, MSB_FIRST=0, in=8'h81 -> ser_out=1 for cycles 1-3, 0 for cycles 4-21, 1 for cycles 22-24; done in cycle 25.
4. DIV=1, in=8'hA5, en=0 for 4 cycles starting in bit 3 -> bit 3 (value 0) visible for 5 cycles; remaining bits unchanged; done in cycle 13.
5. in_valid=1 with in=8'hFF during SHIFT of 8'h00 -> not accepted (in_ready=0). 8'hFF is accepted on the first IDLE edge after done, and sent as eight 1s.
6. Reset pulse during bit 4 of 8'h3C -> outputs 0 asynchronously, no done. After release, 8'h3C is resent in full: 0,0,1,1,1,1,0,0. With PISO_UNLOADER_PARITY_EN, in=8'h07 -> 9th bit=1 and done in cycle 10.
